// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared types and helpers for the two-layer inference engine:
//                FSM state encoding, width helpers and the accumulator to
//                activation-LUT address mapping (shift, clamp, offset).
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int c_ST_W = 4;

    typedef enum logic [c_ST_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_HID_MAC = 4'd1,
        ST_HID_BP  = 4'd2,
        ST_HID_LUT = 4'd3,
        ST_HID_WR  = 4'd4,
        ST_OUT_MAC = 4'd5,
        ST_OUT_BP  = 4'd6,
        ST_OUT_LUT = 4'd7,
        ST_OUT_WR  = 4'd8,
        ST_DONE    = 4'd9
    } state_t;

    // Address width for a count of n items; never narrower than one bit.
    function automatic int clog2_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Accumulator wide enough that a full dot product can never overflow.
    function automatic int acc_width(input int dw, input int n_in, input int n_hid);
        return 2 * dw + 1 + clog2_w(max_int(n_in, n_hid));
    endfunction

    // Arithmetic shift, clamp to the signed LUT range, then offset so the
    // most negative value maps to address 0.
    function automatic logic [31:0] sat_lut(input logic signed [63:0] acc,
                                            input int frac, input int aw);
        logic signed [63:0] v_sh;
        logic signed [63:0] v_lo;
        logic signed [63:0] v_hi;
        v_sh = acc >>> frac;
        v_hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        v_lo = -(64'sd1 <<< (aw - 1));
        if (v_sh > v_hi) begin
            v_sh = v_hi;
        end else if (v_sh < v_lo) begin
            v_sh = v_lo;
        end
        v_sh = v_sh + (64'sd1 <<< (aw - 1));
        return v_sh[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_mac.sv
`default_nettype none
// ============================================================================
//  Module      : snn_mac
//  Description : Unsigned-activation x signed-weight multiply-accumulate with
//                synchronous clear and enable. Exposes the next accumulator
//                value so the final sum can be consumed on the same edge it
//                is formed.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_mac #(
    parameter int DW    = 8,
    parameter int ACC_W = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic [DW-1:0]           i_act,
    input  logic [DW-1:0]           i_wgt,
    output logic signed [ACC_W-1:0] o_acc_nxt
);

    localparam int c_PW = 2 * DW + 1;

    logic signed [c_PW-1:0]  w_act_ext;
    logic signed [c_PW-1:0]  w_wgt_ext;
    logic signed [c_PW-1:0]  w_prod;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_nxt;

    // Activation is zero-extended, weight sign-extended; the product fits c_PW bits.
    assign w_act_ext = $signed({{DW{1'b0}}, 1'b0, i_act});
    assign w_wgt_ext = $signed({{(DW + 1){i_wgt[DW-1]}}, i_wgt});
    assign w_prod    = w_act_ext * w_wgt_ext;

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        w_acc_nxt = r_acc;
        if (i_clr) begin
            w_acc_nxt = '0;
        end else if (i_en) begin
            w_acc_nxt = r_acc + ACC_W'(w_prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_acc_nxt = w_acc_nxt;

endmodule
`default_nettype wire

// File: rtl/snn_layer_engine.sv
`default_nettype none
// ============================================================================
//  Module      : snn_layer_engine
//  Description : Two-layer (input -> hidden -> output) inference sequencer.
//                Streams operands from external 1-cycle-latency memories,
//                keeps hidden activations locally and reports the argmax of
//                the output layer (ties resolve to the lowest index).
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_layer_engine
    import snn_pkg::*;
#(
    parameter int N_IN   = 784,
    parameter int N_HID  = 32,
    parameter int N_OUT  = 10,
    parameter int DW     = 8,
    parameter int LUT_AW = 11,
    parameter int FRAC   = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic [clog2_w(N_IN)-1:0]         addr_input_unit,
    input  logic [DW-1:0]                    q_input,
    output logic [clog2_w(N_IN*N_HID)-1:0]   addr_w_hid,
    input  logic [DW-1:0]                    q_w_hid,
    output logic [clog2_w(N_HID*N_OUT)-1:0]  addr_w_out,
    input  logic [DW-1:0]                    q_w_out,
    output logic [LUT_AW-1:0]                addr_lut,
    input  logic [DW-1:0]                    q_lut,
    output logic                             busy,
    output logic                             done,
    output logic [clog2_w(N_OUT)-1:0]        digit
);

    localparam int c_IN_AW  = clog2_w(N_IN);
    localparam int c_HID_AW = clog2_w(N_HID);
    localparam int c_OUT_AW = clog2_w(N_OUT);
    localparam int c_WH_AW  = clog2_w(N_IN * N_HID);
    localparam int c_WO_AW  = clog2_w(N_HID * N_OUT);
    localparam int c_ACC_W  = acc_width(DW, N_IN, N_HID);

    localparam logic [c_IN_AW-1:0]  c_IN_LAST  = c_IN_AW'(N_IN - 1);
    localparam logic [c_HID_AW-1:0] c_HID_LAST = c_HID_AW'(N_HID - 1);
    localparam logic [c_OUT_AW-1:0] c_OUT_LAST = c_OUT_AW'(N_OUT - 1);

    state_t                     r_state,     w_state_nxt;
    logic [c_IN_AW-1:0]         r_i,         w_i_nxt;
    logic [c_HID_AW-1:0]        r_h,         w_h_nxt;
    logic [c_HID_AW-1:0]        r_j,         w_j_nxt;
    logic [c_OUT_AW-1:0]        r_o,         w_o_nxt;
    logic [c_WH_AW-1:0]         r_addr_wh,   w_addr_wh_nxt;
    logic [c_WO_AW-1:0]         r_addr_wo,   w_addr_wo_nxt;
    logic [LUT_AW-1:0]          r_addr_lut,  w_addr_lut_nxt;
    logic [DW-1:0]              r_best,      w_best_nxt;
    logic [c_OUT_AW-1:0]        r_best_idx,  w_best_idx_nxt;
    logic [c_OUT_AW-1:0]        r_digit,     w_digit_nxt;

    logic [DW-1:0]              r_hidden [N_HID];
    logic [DW-1:0]              r_hid_rd;

    logic                       w_mac_clr;
    logic                       w_mac_en;
    logic                       w_sel_out;
    logic [DW-1:0]              w_mac_act;
    logic [DW-1:0]              w_mac_wgt;
    logic signed [c_ACC_W-1:0]  w_acc_sum;
    logic [LUT_AW-1:0]          w_lut_addr;

    // Operands come from the input RAM for the hidden layer and from the
    // local hidden array for the output layer.
    assign w_mac_act  = w_sel_out ? r_hid_rd : q_input;
    assign w_mac_wgt  = w_sel_out ? q_w_out  : q_w_hid;
    assign w_lut_addr = LUT_AW'(sat_lut(64'(w_acc_sum), FRAC, LUT_AW));

    snn_mac #(
        .DW    (DW),
        .ACC_W (c_ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_mac_clr),
        .i_en      (w_mac_en),
        .i_act     (w_mac_act),
        .i_wgt     (w_mac_wgt),
        .o_acc_nxt (w_acc_sum)
    );

    // Next-state, counter/address sequencing and argmax tracking.
    always_comb begin
        w_state_nxt    = r_state;
        w_i_nxt        = r_i;
        w_h_nxt        = r_h;
        w_j_nxt        = r_j;
        w_o_nxt        = r_o;
        w_addr_wh_nxt  = r_addr_wh;
        w_addr_wo_nxt  = r_addr_wo;
        w_addr_lut_nxt = r_addr_lut;
        w_best_nxt     = r_best;
        w_best_idx_nxt = r_best_idx;
        w_digit_nxt    = r_digit;
        w_mac_clr      = 1'b0;
        w_mac_en       = 1'b0;
        w_sel_out      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_HID_MAC;
                    w_i_nxt       = '0;
                    w_h_nxt       = '0;
                    w_addr_wh_nxt = '0;
                    w_mac_clr     = 1'b1;
                end
            end
            ST_HID_MAC: begin
                // Data for address i-1 arrives now; nothing is valid at i=0.
                w_mac_en = (r_i != '0);
                if ((r_i == c_IN_LAST) && (r_h == c_HID_LAST)) begin
                    w_addr_wh_nxt = '0;
                end else begin
                    w_addr_wh_nxt = r_addr_wh + c_WH_AW'(1);
                end
                if (r_i == c_IN_LAST) begin
                    w_state_nxt = ST_HID_BP;
                end else begin
                    w_i_nxt = r_i + c_IN_AW'(1);
                end
            end
            ST_HID_BP: begin
                w_mac_en       = 1'b1;
                w_addr_lut_nxt = w_lut_addr;
                w_state_nxt    = ST_HID_LUT;
            end
            ST_HID_LUT: begin
                w_state_nxt = ST_HID_WR;
            end
            ST_HID_WR: begin
                w_mac_clr = 1'b1;
                w_i_nxt   = '0;
                if (r_h == c_HID_LAST) begin
                    w_state_nxt   = ST_OUT_MAC;
                    w_o_nxt       = '0;
                    w_j_nxt       = '0;
                    w_addr_wo_nxt = '0;
                end else begin
                    w_h_nxt     = r_h + c_HID_AW'(1);
                    w_state_nxt = ST_HID_MAC;
                end
            end
            ST_OUT_MAC: begin
                w_sel_out = 1'b1;
                w_mac_en  = (r_j != '0);
                if ((r_j == c_HID_LAST) && (r_o == c_OUT_LAST)) begin
                    w_addr_wo_nxt = '0;
                end else begin
                    w_addr_wo_nxt = r_addr_wo + c_WO_AW'(1);
                end
                if (r_j == c_HID_LAST) begin
                    w_state_nxt = ST_OUT_BP;
                end else begin
                    w_j_nxt = r_j + c_HID_AW'(1);
                end
            end
            ST_OUT_BP: begin
                w_sel_out      = 1'b1;
                w_mac_en       = 1'b1;
                w_addr_lut_nxt = w_lut_addr;
                w_state_nxt    = ST_OUT_LUT;
            end
            ST_OUT_LUT: begin
                w_state_nxt = ST_OUT_WR;
            end
            ST_OUT_WR: begin
                w_mac_clr = 1'b1;
                w_j_nxt   = '0;
                // Strictly greater keeps the lowest index on ties.
                if ((r_o == '0) || (q_lut > r_best)) begin
                    w_best_nxt     = q_lut;
                    w_best_idx_nxt = r_o;
                end
                if (r_o == c_OUT_LAST) begin
                    w_digit_nxt = w_best_idx_nxt;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_o_nxt     = r_o + c_OUT_AW'(1);
                    w_state_nxt = ST_OUT_MAC;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control and address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_i        <= '0;
            r_h        <= '0;
            r_j        <= '0;
            r_o        <= '0;
            r_addr_wh  <= '0;
            r_addr_wo  <= '0;
            r_addr_lut <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_digit    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_i        <= w_i_nxt;
            r_h        <= w_h_nxt;
            r_j        <= w_j_nxt;
            r_o        <= w_o_nxt;
            r_addr_wh  <= w_addr_wh_nxt;
            r_addr_wo  <= w_addr_wo_nxt;
            r_addr_lut <= w_addr_lut_nxt;
            r_best     <= w_best_nxt;
            r_best_idx <= w_best_idx_nxt;
            r_digit    <= w_digit_nxt;
        end
    end

    // Hidden activation store; the read port is registered to line up with
    // the output-weight ROM latency. Contents need no reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_HID_WR) begin
            r_hidden[r_h] <= q_lut;
        end
        r_hid_rd <= r_hidden[r_j];
    end

    assign addr_input_unit = r_i;
    assign addr_w_hid      = r_addr_wh;
    assign addr_w_out      = r_addr_wo;
    assign addr_lut        = r_addr_lut;
    assign busy            = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done            = (r_state == ST_DONE);
    assign digit           = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_snn_layer_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_layer_engine
//  Description : Self-checking bench for snn_layer_engine (4/2/3 network).
//                Memory models feed the DUT; a reference model pushes the
//                expected LUT addresses, busy, done and digit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_layer_engine;

    localparam int N_IN   = 4;
    localparam int N_HID  = 2;
    localparam int N_OUT  = 3;
    localparam int DW     = 8;
    localparam int LUT_AW = 11;
    localparam int FRAC   = 0;
    localparam int LAT    = N_HID * (N_IN + 3) + N_OUT * (N_HID + 3) + 1;
    localparam int OFS    = 2 ** (LUT_AW - 1);

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  addr_input_unit;
    logic [7:0]  q_input;
    logic [2:0]  addr_w_hid;
    logic [7:0]  q_w_hid;
    logic [2:0]  addr_w_out;
    logic [7:0]  q_w_out;
    logic [10:0] addr_lut;
    logic [7:0]  q_lut;
    logic        busy;
    logic        done;
    logic [1:0]  digit;

    logic [7:0]  in_mem [N_IN];
    byte         wh_mem [N_IN*N_HID];
    byte         wo_mem [N_HID*N_OUT];

    typedef struct {
        int cyc;
        int kind;   // 0: addr_lut, 1: done+digit, 2: busy
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   vec;
    int   errs;

    snn_layer_engine #(
        .N_IN   (N_IN),
        .N_HID  (N_HID),
        .N_OUT  (N_OUT),
        .DW     (DW),
        .LUT_AW (LUT_AW),
        .FRAC   (FRAC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .addr_input_unit (addr_input_unit),
        .q_input         (q_input),
        .addr_w_hid      (addr_w_hid),
        .q_w_hid         (q_w_hid),
        .addr_w_out      (addr_w_out),
        .q_w_out         (q_w_out),
        .addr_lut        (addr_lut),
        .q_lut           (q_lut),
        .busy            (busy),
        .done            (done),
        .digit           (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Activation LUT: identity above the midpoint, clamped to the data range.
    function automatic int lut_val(input int a);
        if (a < OFS) return 0;
        if (a - OFS > 255) return 255;
        return a - OFS;
    endfunction

    function automatic int lut_addr(input int acc);
        int s;
        s = acc >>> FRAC;
        if (s > OFS - 1) s = OFS - 1;
        if (s < -OFS) s = -OFS;
        return s + OFS;
    endfunction

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        q_input <= in_mem[addr_input_unit];
        q_w_hid <= wh_mem[addr_w_hid];
        q_w_out <= wo_mem[addr_w_out];
        q_lut   <= 8'(lut_val(int'(addr_lut)));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int k, input int v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Reference model for a run whose start is sampled at the end of cycle t0.
    task automatic push_expect(input int t0);
        int hid [N_HID];
        int acc;
        int a;
        int v;
        int best;
        int bidx;
        push(t0 + 1, 2, 1);
        for (int h = 0; h < N_HID; h++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++) acc += int'(in_mem[i]) * int'(wh_mem[h*N_IN+i]);
            a = lut_addr(acc);
            push(t0 + h * (N_IN + 3) + N_IN + 2, 0, a);
            hid[h] = lut_val(a);
        end
        best = 0;
        bidx = 0;
        for (int o = 0; o < N_OUT; o++) begin
            acc = 0;
            for (int j = 0; j < N_HID; j++) acc += hid[j] * int'(wo_mem[o*N_HID+j]);
            a = lut_addr(acc);
            push(t0 + N_HID * (N_IN + 3) + o * (N_HID + 3) + N_HID + 2, 0, a);
            v = lut_val(a);
            if (o == 0 || v > best) begin
                best = v;
                bidx = o;
            end
        end
        push(t0 + LAT - 1, 2, 1);
        push(t0 + LAT, 1, bidx);
        push(t0 + LAT, 2, 0);
    endtask

    // Advance one cycle and check everything scheduled for it; done must be
    // low whenever no completion is expected.
    task automatic step();
        exp_t e;
        bit   exp_done;
        exp_done = 1'b0;
        @(negedge clk);
        cyc++;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (e.kind == 0) begin
                chk("addr_lut", 32'(addr_lut), e.val);
            end else if (e.kind == 1) begin
                exp_done = 1'b1;
                chk("done", 32'(done), 1);
                chk("digit", 32'(digit), e.val);
            end else begin
                chk("busy", 32'(busy), e.val);
            end
        end
        if (!exp_done) chk("no_done", 32'(done), 0);
    endtask

    task automatic do_run();
        int t0;
        t0 = cyc;
        push_expect(t0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (LAT + 1) step();
        chk("busy_after", 32'(busy), 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_digit"}, 32'(digit), 0);
        chk({tag, "_ain"},   32'(addr_input_unit), 0);
        chk({tag, "_awh"},   32'(addr_w_hid), 0);
        chk({tag, "_awo"},   32'(addr_w_out), 0);
        chk({tag, "_alut"},  32'(addr_lut), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_IN; i++) in_mem[i] = 8'($urandom_range(0, 255));
        for (int k = 0; k < N_IN*N_HID; k++) wh_mem[k] = byte'(int'($urandom_range(0, 8)) - 4);
        for (int k = 0; k < N_HID*N_OUT; k++) wo_mem[k] = byte'(int'($urandom_range(0, 8)) - 4);
    endtask

    initial begin
        int t0;
        vec   = 0;
        errs  = 0;
        cyc   = 0;
        rst_n = 1'b0;
        start = 1'b0;

        // Run A: inputs 10..40, unit hidden weights -> hidden acc 100 each.
        for (int i = 0; i < N_IN; i++) in_mem[i] = 8'(10 * (i + 1));
        for (int k = 0; k < N_IN*N_HID; k++) wh_mem[k] = 8'sd1;
        wo_mem[0] = 8'sd1;  wo_mem[1] = 8'sd0;
        wo_mem[2] = 8'sd1;  wo_mem[3] = 8'sd1;
        wo_mem[4] = 8'sd0;  wo_mem[5] = 8'sd2;

        repeat (3) step();
        chk_reset_state("rst");
        rst_n = 1'b1;
        repeat (2) step();
        chk_reset_state("idle");

        do_run();                               // outputs 100/200/200 -> digit 1

        // Run B: negative saturation of every hidden neuron.
        for (int i = 0; i < N_IN; i++) in_mem[i] = 8'd255;
        for (int k = 0; k < N_IN*N_HID; k++) wh_mem[k] = -8'sd128;
        do_run();

        // Run C: positive saturation, winner is the last output.
        for (int k = 0; k < N_IN*N_HID; k++) wh_mem[k] = 8'sd127;
        wo_mem[0] = -8'sd1; wo_mem[1] = -8'sd1;
        wo_mem[2] = 8'sd0;  wo_mem[3] = -8'sd1;
        wo_mem[4] = 8'sd1;  wo_mem[5] = 8'sd1;
        do_run();

        // Reset during OUT_MAC, then a clean inference.
        t0 = cyc;
        push_expect(t0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (N_HID * (N_IN + 3) + 1) step();
        sb.delete();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset_state("midrst");
        repeat (4) step();
        chk("midrst_no_result", 32'(done), 0);
        fill_random();
        do_run();

        // start held high across a whole run: one inference per IDLE entry.
        fill_random();
        t0 = cyc;
        push_expect(t0);
        push_expect(t0 + LAT + 1);
        start = 1'b1;
        repeat (LAT + 1) step();
        step();
        start = 1'b0;
        repeat (LAT + 2) step();
        chk("held_busy_after", 32'(busy), 0);
        chk("held_sb_drained", sb.size(), 0);

        // A few more random networks.
        for (int r = 0; r < 3; r++) begin
            fill_random();
            do_run();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
